// File: rtl/sys1_video_timing_if.sv
// Pixel-side bundle between the raster timing block and the system top / video mixer.
// master = timing generator (drives counters, strobe, RGB and flags); slave = consumer returning POUT.
interface sys1_video_timing_if;
  logic [7:0]  POUT;
  logic [8:0]  PH;
  logic [8:0]  PV;
  logic        ce_pix;
  logic        hblank;
  logic        vblank;
  logic        hsync;
  logic        vsync;
  logic [23:0] rgb;

  modport master (
    input  POUT,
    output PH, PV, ce_pix, hblank, vblank, hsync, vsync, rgb
  );

  modport slave (
    output POUT,
    input  PH, PV, ce_pix, hblank, vblank, hsync, vsync, rgb
  );
endinterface

// File: rtl/sys1_video_timing.sv
// System 1/2 raster timing: 6 MHz strobe, PH/PV counters, POUT -> 24-bit RGB with aligned blank/sync.
// RGB/flags for a PH/PV land PIX_DELAY+1 strobes after it is driven; no backpressure, outputs hold between strobes.
module sys1_video_timing #(
  parameter int CLK_DIV      = 8,
  parameter int H_TOTAL      = 384,
  parameter int H_ACTIVE     = 256,
  parameter int H_SYNC_START = 288,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_TOTAL      = 264,
  parameter int V_ACTIVE     = 224,
  parameter int V_SYNC_START = 236,
  parameter int V_SYNC_LEN   = 3,
  parameter int PIX_DELAY    = 2
) (
  input  logic                clk48M,
  input  logic                reset_n,
  sys1_video_timing_if.master vid
);
  localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [8:0]      PH_LAST  = 9'(H_TOTAL - 1);
  localparam logic [8:0]      PV_LAST  = 9'(V_TOTAL - 1);
  localparam logic [8:0]      H_ACT    = 9'(H_ACTIVE);
  localparam logic [8:0]      V_ACT    = 9'(V_ACTIVE);
  localparam logic [8:0]      HS_BEG   = 9'(H_SYNC_START);
  localparam logic [8:0]      HS_END   = 9'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [8:0]      VS_BEG   = 9'(V_SYNC_START);
  localparam logic [8:0]      VS_END   = 9'(V_SYNC_START + V_SYNC_LEN);

  logic [DW-1:0] div;
  logic          ce;
  logic [8:0]    ph;
  logic [8:0]    pv;
  logic [3:0]    flags_raw;
  logic [3:0]    flag_dly [PIX_DELAY];
  logic [3:0]    flags_out;
  logic [3:0]    flags_tap;
  logic [2:0]    r;
  logic [2:0]    g;
  logic [1:0]    b;
  logic [23:0]   rgb_exp;
  logic [23:0]   rgb_q;

  assign ce = (div == DIV_LAST);

  // Flag order throughout: {hb, vb, hs, vs}
  always_comb begin
    flags_raw = {ph >= H_ACT,
                 pv >= V_ACT,
                 (ph >= HS_BEG) && (ph < HS_END),
                 (pv >= VS_BEG) && (pv < VS_END)};
  end

  assign flags_tap = flag_dly[PIX_DELAY-1];

  // Bit replication maps 3/2-bit codes onto 0..255 with both end points exact.
  assign r       = vid.POUT[2:0];
  assign g       = vid.POUT[5:3];
  assign b       = vid.POUT[7:6];
  assign rgb_exp = {r, r, r[2:1], g, g, g[2:1], b, b, b, b};

  always_ff @(posedge clk48M) begin
    if (!reset_n) begin
      div       <= '0;
      ph        <= '0;
      pv        <= '0;
      flags_out <= '0;
      rgb_q     <= '0;
      for (int i = 0; i < PIX_DELAY; i++) flag_dly[i] <= '0;
    end else begin
      div <= ce ? '0 : div + DW'(1);
      if (ce) begin
        if (ph == PH_LAST) begin
          ph <= '0;
          pv <= (pv == PV_LAST) ? 9'd0 : pv + 9'd1;
        end else begin
          ph <= ph + 9'd1;
        end
        flag_dly[0] <= flags_raw;
        for (int i = 1; i < PIX_DELAY; i++) flag_dly[i] <= flag_dly[i-1];
        // POUT returning now belongs to the PH/PV whose flags sit at the end of the delay line.
        flags_out <= flags_tap;
        rgb_q     <= (flags_tap[3] | flags_tap[2]) ? 24'd0 : rgb_exp;
      end
    end
  end

  assign vid.PH     = ph;
  assign vid.PV     = pv;
  assign vid.ce_pix = ce;
  assign vid.hblank = flags_out[3];
  assign vid.vblank = flags_out[2];
  assign vid.hsync  = flags_out[1];
  assign vid.vsync  = flags_out[0];
  assign vid.rgb    = rgb_q;
endmodule
